hazard_unit: RTL

Parametrised successor to the pipeline stall controller. It detects read-after-write hazards between decode-stage source registers and any number of in-flight producer stages, with an optional forwarding mode in which only load-use hazards stall. It also runs a branch-resolution state machine that holds fetch and then flushes for a fixed penalty. It sits beside the fetch/decode/execute/writeback stages and drives their halt and flush controls.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_match.sv | 35 +++
 rtl/hazard_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard / branch-flush controller.
package hazard_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source operand against every in-flight producer and
// reports whether that operand must stall decode.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_PROD    = 3,
  parameter int FORWARD_EN  = 0,
  parameter int ZERO_REG_EN = 1
) (
  input  logic [ADDR_W-1:0]          src_addr,
  input  logic                       src_valid,
  input  logic [NUM_PROD-1:0]        prod_regwrite,
  input  logic [NUM_PROD*ADDR_W-1:0] prod_addr,
  input  logic [NUM_PROD-1:0]        prod_is_load,
  output logic                       stall
);

  logic                src_live;
  logic [NUM_PROD-1:0] hit;
  logic [NUM_PROD-1:0] gate;

  // The zero register is hard-wired, so reading it never depends on a producer.
  assign src_live = src_valid & ~((ZERO_REG_EN != 0) && (src_addr == '0));

  for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_prod
    assign hit[gi] = src_live & prod_regwrite[gi] &
                     (prod_addr[gi*ADDR_W +: ADDR_W] == src_addr);
    // With bypassing, only a load still in execute cannot be forwarded in time.
    assign gate[gi] = (FORWARD_EN == 0) || ((gi == 0) && prod_is_load[gi]);
  end

  assign stall = |(hit & gate);

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard detection plus branch hold/flush sequencing for an in-order
// pipeline; drives the per-stage halt and flush controls.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NUM_SRC        = 2,
  parameter int NUM_PROD       = 3,
  parameter int FORWARD_EN     = 0,
  parameter int ZERO_REG_EN    = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*ADDR_W-1:0]  dsrc_addr,
  input  logic [NUM_SRC-1:0]         dsrc_valid,
  input  logic [NUM_PROD-1:0]        prod_regwrite,
  input  logic [NUM_PROD*ADDR_W-1:0] prod_addr,
  input  logic [NUM_PROD-1:0]        prod_is_load,
  input  logic                       dbranch,
  input  logic                       branch_resolved,
  input  logic                       branch_taken,
  output logic                       halt_fetch,
  output logic                       halt_decode,
  output logic                       halt_execution,
  output logic                       halt_writeback,
  output logic                       flush_decode,
  output logic [CNT_W-1:0]           stall_count,
  output logic                       protocol_err
);

  localparam int PEN_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
  localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(BRANCH_PENALTY - 1);

  logic [NUM_SRC-1:0] src_stall;
  logic               raw_stall;
  hz_state_t          state_reg, state_next;
  logic [PEN_W-1:0]   pen_reg, pen_next;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic               perr_reg, perr_next;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_match #(
      .ADDR_W      (ADDR_W),
      .NUM_PROD    (NUM_PROD),
      .FORWARD_EN  (FORWARD_EN),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match (
      .src_addr      (dsrc_addr[gi*ADDR_W +: ADDR_W]),
      .src_valid     (dsrc_valid[gi]),
      .prod_regwrite (prod_regwrite),
      .prod_addr     (prod_addr),
      .prod_is_load  (prod_is_load),
      .stall         (src_stall[gi])
    );
  end

  assign raw_stall = |src_stall;

  always_comb begin
    state_next = state_reg;
    pen_next   = pen_reg;
    perr_next  = perr_reg;
    case (state_reg)
      RUN: begin
        // The branch leaves decode only once its own operands are clear.
        if (dbranch && !raw_stall) state_next = BR_WAIT;
        if (branch_resolved) perr_next = 1'b1;
      end
      BR_WAIT: begin
        if (branch_resolved) begin
          if (branch_taken) begin
            state_next = FLUSH;
            pen_next   = PEN_LOAD;
          end else begin
            state_next = RUN;
          end
        end
      end
      FLUSH: begin
        // Whatever sits in decode here is wrong-path, so dbranch is ignored.
        if (pen_reg == '0) state_next = RUN;
        else pen_next = pen_reg - PEN_W'(1);
        if (branch_resolved) perr_next = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    halt_decode  = 1'b0;
    halt_fetch   = 1'b0;
    flush_decode = 1'b0;
    if (!rst) begin
      halt_decode  = raw_stall & (state_reg != FLUSH);
      halt_fetch   = (raw_stall & (state_reg != FLUSH)) | (state_reg == BR_WAIT);
      flush_decode = (state_reg == FLUSH) | ((state_reg == BR_WAIT) & ~raw_stall);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      pen_reg       <= '0;
      stall_cnt_reg <= '0;
      perr_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      pen_reg   <= pen_next;
      perr_reg  <= perr_next;
      if (halt_decode && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign halt_execution = 1'b0;
  assign halt_writeback = 1'b0;
  assign stall_count    = stall_cnt_reg;
  assign protocol_err   = perr_reg;

endmodule
